// File: rtl/vram_rdport_arbiter.sv
// rtl/vram_rdport_arbiter.sv - round-robin VRAM read-port arbiter with tagged in-order responses
// Optional VRAM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins), no rotation pointer.
module vram_rdport_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      ram_addr,
    input  logic [DATA_W-1:0]      ram_rddata
);
    localparam int IDX_W = $clog2(NREQ);

    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] last_addr;
    logic [RD_LAT-1:0] tag_v;
    logic [IDX_W-1:0]  tag_idx [RD_LAT];
    logic [DATA_W-1:0] rdata_q;
    logic              resp_v;

`ifdef VRAM_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last write and wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        if (rst) gnt_any = 1'b0;
    end
`else
    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;

    // Scan offsets high to low so the requester closest to ptr overwrites the rest.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NREQ)) cand = cand - (IDX_W + 1)'(NREQ);
            if (req[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        if (rst) gnt_any = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        if (rst)          ram_addr = '0;
        else if (gnt_any) ram_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        else              ram_addr = last_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
        end else if (gnt_any) begin
            last_addr <= ram_addr;
        end
    end

    // Tag pipeline mirrors the RAM latency so each beat returns to its issuer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= gnt_any;
            tag_idx[0] <= gnt_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    assign resp_v = tag_v[RD_LAT-1] & ~rst;

    always_comb begin
        rvalid = '0;
        if (resp_v) rvalid[tag_idx[RD_LAT-1]] = 1'b1;
    end

    always_comb begin
        if (rst)         rdata = '0;
        else if (resp_v) rdata = ram_rddata;
        else             rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (resp_v) begin
            rdata_q <= ram_rddata;
        end
    end
endmodule

// File: tb/tb_vram_rdport_arbiter.sv
// tb/tb_vram_rdport_arbiter.sv - scoreboard bench for vram_rdport_arbiter
module tb_vram_rdport_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_rddata;

    vram_rdport_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr), .ram_rddata(ram_rddata)
    );

    always #5 clk = ~clk;

    // VRAM model: echoes the address back RD_LAT cycles after it was presented.
    logic [ADDR_W-1:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_rddata = DATA_W'(ram_pipe[RD_LAT-1]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
        int                due;
    } ent_t;
    ent_t sb[$];

    int checks = 0;
    int passes = 0;
    int p = 0;
    logic [ADDR_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_d = '0;
    logic [NREQ-1:0]   exp_gnt = '0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic step(input bit r, input logic [NREQ-1:0] rq, input logic [NREQ*ADDR_W-1:0] ad);
        int gi;
        logic [ADDR_W-1:0] ea;
        @(posedge clk);
        #1;
        rst = r;
        req = rq;
        req_addr = ad;
        @(negedge clk);
        gi = -1;
        exp_gnt = '0;
        if (!r) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gi < 0 && rq[(p + k) % NREQ]) gi = (p + k) % NREQ;
            end
        end
        if (gi >= 0) begin
            exp_gnt[gi] = 1'b1;
            ea = ad[gi*ADDR_W +: ADDR_W];
        end else begin
            ea = r ? '0 : last_a;
        end
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("ram_addr", 64'(ram_addr), 64'(ea));
        if (r) begin
            chk("rvalid_rst", 64'(rvalid), 64'(0));
            chk("rdata_rst", 64'(rdata), 64'(0));
            p = 0;
            last_a = '0;
            last_d = '0;
            sb.delete();
        end else if (gi >= 0) begin
            sb.push_back('{gi, DATA_W'(ea), cyc + RD_LAT});
            last_a = ea;
`ifndef VRAM_ARB_FIXED_PRIO_EN
            p = (gi + 1) % NREQ;
`endif
        end
    endtask

    // Response monitor: every non-reset cycle, rvalid/rdata must match the scoreboard head.
    always @(negedge clk) begin
        if (started && !rst) begin
            logic [NREQ-1:0] erv;
            ent_t e;
            bit has;
            erv = '0;
            has = 0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                has = 1;
                erv[e.idx] = 1'b1;
            end
            chk("rvalid", 64'(rvalid), 64'(erv));
            if (has) begin
                chk("rdata", 64'(rdata), 64'(e.data));
                last_d = e.data;
            end else begin
                chk("rdata_hold", 64'(rdata), 64'(last_d));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NREQ-1:0]        pend;
        logic [NREQ*ADDR_W-1:0] pa;
        started = 1;
        step(1, '1, {3{12'h555}});
        step(1, '1, {3{12'h555}});
        for (int n = 0; n < 6; n++) step(0, '1, {12'h302, 12'h201, 12'h100});
        for (int n = 0; n < 3; n++) step(0, '0, '0);
        step(0, 3'b010, {12'h000, 12'h0A5, 12'h000});
        for (int n = 0; n < 3; n++) step(0, '0, '0);
        for (int k = 0; k < 4; k++) step(0, 3'b001, {24'h0, 12'(12'h010 + k)});
        for (int n = 0; n < 3; n++) step(0, '0, '0);
        step(0, 3'b100, {12'h7EE, 24'h0});
        step(1, '0, '0);
        step(0, '0, '0);
        step(0, '0, '0);
        step(0, '1, {12'h333, 12'h222, 12'h111});
        for (int n = 0; n < 3; n++) step(0, '0, '0);

        pend = '0;
        pa = '0;
        for (int n = 0; n < 400; n++) begin
            bit r;
            r = ($urandom_range(59, 0) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    pa[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                end
            end
            step(r, pend, pa);
            if (r) pend = '0;
            else pend = pend & ~exp_gnt;
        end
        for (int n = 0; n < RD_LAT + 2; n++) step(0, '0, '0);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
